// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX pipeline register: control bundle, bubble value and FSM states.
package id_ex_stage_pkg;

    localparam int unsigned ALUOP_W = 5;

    typedef struct packed {
        logic               regdst;
        logic               alusource;
        logic               memtoreg;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic [1:0]         branchjump;
        logic [ALUOP_W-1:0] aluop;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    typedef enum logic {
        RUN,
        STALL
    } state_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard term: the load now in EX writes a register the instruction in ID reads.
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic       ex_memread_i,
    input  logic       ex_regwrite_i,
    input  logic [4:0] ex_writereg_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_alusource_i,
    input  logic       id_memwrite_i,
    output logic       hazard_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_writereg_i == id_rs_i);
    // Rt is only a source when the ALU takes it (no immediate) or a store writes it to memory.
    assign rt_match = (ex_writereg_i == id_rt_i) & (~id_alusource_i | id_memwrite_i);

    assign hazard_o = ex_memread_i & ex_regwrite_i & (ex_writereg_i != 5'd0)
                      & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall insertion, flush handling and event counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Flush,
    input  logic               ID_RegDst,
    input  logic               ID_ALUSource,
    input  logic               ID_MemToReg,
    input  logic               ID_RegWrite,
    input  logic               ID_MemRead,
    input  logic               ID_MemWrite,
    input  logic [1:0]         ID_BranchJump,
    input  logic [ALUOP_W-1:0] ID_ALUOp,
    input  logic [31:0]        ID_PCPlus4,
    input  logic [31:0]        ID_ReadData1,
    input  logic [31:0]        ID_ReadData2,
    input  logic [31:0]        ID_SignExtImm,
    input  logic [4:0]         ID_Rs,
    input  logic [4:0]         ID_Rt,
    input  logic [4:0]         ID_Rd,
    output logic               EX_RegDst,
    output logic               EX_ALUSource,
    output logic               EX_MemToReg,
    output logic               EX_RegWrite,
    output logic               EX_MemRead,
    output logic               EX_MemWrite,
    output logic [1:0]         EX_BranchJump,
    output logic [ALUOP_W-1:0] EX_ALUOp,
    output logic [31:0]        EX_PCPlus4,
    output logic [31:0]        EX_ReadData1,
    output logic [31:0]        EX_ReadData2,
    output logic [31:0]        EX_SignExtImm,
    output logic [4:0]         EX_Rs,
    output logic [4:0]         EX_Rt,
    output logic [4:0]         EX_Rd,
    output logic [4:0]         EX_WriteReg,
    output logic               Stall,
    output logic [CNT_W-1:0]   StallCount,
    output logic [CNT_W-1:0]   FlushCount
);

    localparam int unsigned CW = 3;

    ctrl_t          id_ctrl;
    ctrl_t          ctrl_q;
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           hazard;
    logic           bubble;
    logic           stall;

    logic [31:0]    pcplus4_q, readdata1_q, readdata2_q, signextimm_q;
    logic [4:0]     rs_q, rt_q, rd_q, writereg_q;
    logic [CNT_W-1:0] stall_count_q, flush_count_q;

    assign id_ctrl = {ID_RegDst, ID_ALUSource, ID_MemToReg, ID_RegWrite,
                      ID_MemRead, ID_MemWrite, ID_BranchJump, ID_ALUOp};

    hazard_detect u_hazard_detect (
        .ex_memread_i   (ctrl_q.memread),
        .ex_regwrite_i  (ctrl_q.regwrite),
        .ex_writereg_i  (writereg_q),
        .id_rs_i        (ID_Rs),
        .id_rt_i        (ID_Rt),
        .id_alusource_i (ID_ALUSource),
        .id_memwrite_i  (ID_MemWrite),
        .hazard_o       (hazard)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        if (Flush) begin
            // Flush wins in both states and aborts any stall in progress.
            bubble  = 1'b1;
            state_d = RUN;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hazard) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = STALL;
                            cnt_d   = CW'(LOAD_STALL_CYCLES - 1);
                        end
                    end
                end
                STALL: begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A bubble zeroes only the control bundle; data and specifiers keep their old values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ctrl_q       <= BUBBLE;
            pcplus4_q    <= '0;
            readdata1_q  <= '0;
            readdata2_q  <= '0;
            signextimm_q <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            writereg_q   <= '0;
        end else if (bubble) begin
            ctrl_q <= BUBBLE;
        end else begin
            ctrl_q       <= id_ctrl;
            pcplus4_q    <= ID_PCPlus4;
            readdata1_q  <= ID_ReadData1;
            readdata2_q  <= ID_ReadData2;
            signextimm_q <= ID_SignExtImm;
            rs_q         <= ID_Rs;
            rt_q         <= ID_Rt;
            rd_q         <= ID_Rd;
            writereg_q   <= ID_RegDst ? ID_Rd : ID_Rt;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (stall && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
            if (Flush && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + CNT_W'(1);
            end
        end
    end

    assign EX_RegDst     = ctrl_q.regdst;
    assign EX_ALUSource  = ctrl_q.alusource;
    assign EX_MemToReg   = ctrl_q.memtoreg;
    assign EX_RegWrite   = ctrl_q.regwrite;
    assign EX_MemRead    = ctrl_q.memread;
    assign EX_MemWrite   = ctrl_q.memwrite;
    assign EX_BranchJump = ctrl_q.branchjump;
    assign EX_ALUOp      = ctrl_q.aluop;
    assign EX_PCPlus4    = pcplus4_q;
    assign EX_ReadData1  = readdata1_q;
    assign EX_ReadData2  = readdata2_q;
    assign EX_SignExtImm = signextimm_q;
    assign EX_Rs         = rs_q;
    assign EX_Rt         = rt_q;
    assign EX_Rd         = rd_q;
    assign EX_WriteReg   = writereg_q;
    assign Stall         = stall;
    assign StallCount    = stall_count_q;
    assign FlushCount    = flush_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Random and directed stimulus for two id_ex_stage configurations against a remaining-stall-count model.
module tb_id_ex_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Flush;
    logic [12:0] id_ctrl;   // {RegDst,ALUSource,MemToReg,RegWrite,MemRead,MemWrite,BJ[1:0],ALUOp[4:0]}
    logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;

    logic [12:0] ex_ctrl [2];
    logic [31:0] ex_pc [2], ex_rd1 [2], ex_rd2 [2], ex_imm [2];
    logic [19:0] ex_spec [2];
    logic [63:0] ex_sc [2], ex_fc [2];
    logic        stall_w [2];

    int compared   = 0;
    int mismatched = 0;

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned LSC = (g == 0) ? 1 : 3;
        localparam int unsigned CW  = (g == 0) ? 32 : 4;
        logic          regdst, alusrc, memtoreg, regwrite, memread, memwrite;
        logic [1:0]    bj;
        logic [4:0]    aluop, rs, rt, rd, wr;
        logic [31:0]   pc, rd1, rd2, imm;
        logic          stall;
        logic [CW-1:0] sc, fc;

        id_ex_stage #(.LOAD_STALL_CYCLES(LSC), .CNT_W(CW)) u_dut (
            .Clk(Clk), .Reset(Reset), .Flush(Flush),
            .ID_RegDst(id_ctrl[12]), .ID_ALUSource(id_ctrl[11]), .ID_MemToReg(id_ctrl[10]),
            .ID_RegWrite(id_ctrl[9]), .ID_MemRead(id_ctrl[8]), .ID_MemWrite(id_ctrl[7]),
            .ID_BranchJump(id_ctrl[6:5]), .ID_ALUOp(id_ctrl[4:0]),
            .ID_PCPlus4(id_pc), .ID_ReadData1(id_rd1), .ID_ReadData2(id_rd2),
            .ID_SignExtImm(id_imm), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_Rd(id_rd),
            .EX_RegDst(regdst), .EX_ALUSource(alusrc), .EX_MemToReg(memtoreg),
            .EX_RegWrite(regwrite), .EX_MemRead(memread), .EX_MemWrite(memwrite),
            .EX_BranchJump(bj), .EX_ALUOp(aluop), .EX_PCPlus4(pc), .EX_ReadData1(rd1),
            .EX_ReadData2(rd2), .EX_SignExtImm(imm), .EX_Rs(rs), .EX_Rt(rt), .EX_Rd(rd),
            .EX_WriteReg(wr), .Stall(stall), .StallCount(sc), .FlushCount(fc)
        );

        assign ex_ctrl[g] = {regdst, alusrc, memtoreg, regwrite, memread, memwrite, bj, aluop};
        assign ex_pc[g]   = pc;
        assign ex_rd1[g]  = rd1;
        assign ex_rd2[g]  = rd2;
        assign ex_imm[g]  = imm;
        assign ex_spec[g] = {rs, rt, rd, wr};
        assign ex_sc[g]   = 64'(sc);
        assign ex_fc[g]   = 64'(fc);
        assign stall_w[g] = stall;
    end

    typedef struct {
        logic [12:0] ctrl;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd, wr;
        int          stall_left;   // stall cycles still owed after the current one
        logic [63:0] sc, fc;
    } mdl_t;

    mdl_t m [2];
    int   lsc [2] = '{1, 3};
    int   cw  [2] = '{32, 4};
    logic exp_stall [2];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int g = 0; g < 2; g++) begin
            m[g] = '{ctrl: '0, pc: '0, rd1: '0, rd2: '0, imm: '0, rs: '0, rt: '0, rd: '0,
                     wr: '0, stall_left: 0, sc: '0, fc: '0};
        end
    endtask

    // Advances one configuration's model by the cycle about to be clocked in.
    task automatic model_step(input int g, output logic st);
        mdl_t        s;
        logic        haz, bub;
        logic [63:0] maxv;
        s    = m[g];
        haz  = s.ctrl[8] && s.ctrl[9] && (s.wr != 0)
               && ((s.wr == id_rs) || ((s.wr == id_rt) && (!id_ctrl[11] || id_ctrl[7])));
        st   = 1'b0;
        bub  = 1'b0;
        if (Flush) begin
            bub = 1'b1;
            s.stall_left = 0;
        end else if (s.stall_left > 0) begin
            st = 1'b1; bub = 1'b1;
            s.stall_left--;
        end else if (haz) begin
            st = 1'b1; bub = 1'b1;
            s.stall_left = lsc[g] - 1;
        end
        if (bub) begin
            s.ctrl = '0;
        end else begin
            s.ctrl = id_ctrl; s.pc = id_pc; s.rd1 = id_rd1; s.rd2 = id_rd2; s.imm = id_imm;
            s.rs = id_rs; s.rt = id_rt; s.rd = id_rd;
            s.wr = id_ctrl[12] ? id_rd : id_rt;
        end
        maxv = (64'd1 << cw[g]) - 64'd1;
        if (st && s.sc < maxv) s.sc++;
        if (Flush && s.fc < maxv) s.fc++;
        m[g] = s;
    endtask

    task automatic check_outputs(input int g);
        check_val($sformatf("d%0d.ctrl", g), 64'(ex_ctrl[g]), 64'(m[g].ctrl));
        check_val($sformatf("d%0d.pc", g), 64'(ex_pc[g]), 64'(m[g].pc));
        check_val($sformatf("d%0d.rd1", g), 64'(ex_rd1[g]), 64'(m[g].rd1));
        check_val($sformatf("d%0d.rd2", g), 64'(ex_rd2[g]), 64'(m[g].rd2));
        check_val($sformatf("d%0d.imm", g), 64'(ex_imm[g]), 64'(m[g].imm));
        check_val($sformatf("d%0d.spec", g), 64'(ex_spec[g]),
                  64'({m[g].rs, m[g].rt, m[g].rd, m[g].wr}));
        check_val($sformatf("d%0d.stallcnt", g), ex_sc[g], m[g].sc);
        check_val($sformatf("d%0d.flushcnt", g), ex_fc[g], m[g].fc);
    endtask

    // Called just after a negedge with inputs already driven; returns just after the next negedge.
    task automatic cycle();
        for (int g = 0; g < 2; g++) model_step(g, exp_stall[g]);
        #1;
        for (int g = 0; g < 2; g++)
            check_val($sformatf("d%0d.stall", g), 64'(stall_w[g]), 64'(exp_stall[g]));
        @(posedge Clk);
        #1;
        for (int g = 0; g < 2; g++) check_outputs(g);
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        model_clear();
        for (int g = 0; g < 2; g++) begin
            check_val($sformatf("d%0d.rst_stall", g), 64'(stall_w[g]), 64'd0);
            check_outputs(g);
        end
        Reset = 1'b0;
    endtask

    task automatic instr(input logic [12:0] c, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] rd1);
        id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd; id_rd1 = rd1;
        id_pc = id_pc + 32'd4; id_rd2 = $urandom; id_imm = $urandom;
    endtask

    task automatic rand_inputs();
        id_ctrl = 13'($urandom);
        id_ctrl[8] = ($urandom_range(0, 1) == 0);
        id_ctrl[9] = ($urandom_range(0, 3) != 0);
        id_rs   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        id_rt   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        id_rd   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        id_pc   = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
        Flush   = ($urandom_range(0, 9) == 0);
    endtask

    localparam logic [12:0] ADDI = 13'b1_1_0_1_0_0_00_00010;
    localparam logic [12:0] LW   = 13'b0_1_1_1_1_0_00_00000;
    localparam logic [12:0] ADD  = 13'b1_0_0_1_0_0_00_00001;
    localparam logic [12:0] SW   = 13'b0_1_0_0_0_1_00_00000;

    initial begin
        Reset = 1'b1; Flush = 1'b0;
        id_ctrl = '0; id_pc = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0;
        model_clear();
        repeat (2) @(negedge Clk);
        for (int g = 0; g < 2; g++) check_outputs(g);
        Reset = 1'b0;

        // Pass-through of addi
        instr(ADDI, 5'd1, 5'd2, 5'd8, 32'h10);
        cycle();
        check_val("addi.aluop", 64'(ex_ctrl[0][4:0]), 64'd2);
        check_val("addi.wr", 64'(ex_spec[0][4:0]), 64'd8);

        // Load-use: lw $9 then add using Rs=$9, held until it latches
        instr(LW, 5'd3, 5'd9, 5'd0, 32'h0);
        cycle();
        instr(ADD, 5'd9, 5'd4, 5'd10, 32'h20);
        repeat (4) cycle();
        check_val("ldu.sc1", ex_sc[0], 64'd1);
        check_val("ldu.sc3", ex_sc[1], 64'd3);

        // Store consumer through Rt, then false hazards ($0 target, immediate-form Rt)
        instr(LW, 5'd3, 5'd9, 5'd0, 32'h0);  cycle();
        instr(SW, 5'd5, 5'd9, 5'd0, 32'h0);  repeat (4) cycle();
        instr(LW, 5'd3, 5'd0, 5'd0, 32'h0);  cycle();
        instr(ADD, 5'd0, 5'd0, 5'd11, 32'h0); cycle();
        instr(LW, 5'd3, 5'd9, 5'd0, 32'h0);  cycle();
        instr(ADDI, 5'd6, 5'd9, 5'd12, 32'h0); cycle();

        // Flush on the second stall cycle aborts the 3-cycle stall
        instr(LW, 5'd3, 5'd7, 5'd0, 32'h0);  cycle();
        instr(ADD, 5'd7, 5'd4, 5'd13, 32'h0); cycle();
        Flush = 1'b1; cycle();
        Flush = 1'b0; repeat (2) cycle();

        // Reset while the 3-cycle configuration is stalled
        instr(LW, 5'd3, 5'd7, 5'd0, 32'h0);  cycle();
        instr(ADD, 5'd7, 5'd4, 5'd13, 32'h0); cycle();
        do_reset();

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end
            rand_inputs();
            cycle();
        end

        // Saturation of the 4-bit flush counter
        do_reset();
        Flush = 1'b1;
        repeat (20) cycle();
        check_val("sat.fc4", ex_fc[1], 64'd15);
        check_val("sat.fc32", ex_fc[0], 64'd20);
        Flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between the decode stage (instruction decoder plus register file) and the execute stage (ALU, branch compare) of the MIPS datapath.
- Latches the decoded control bundle and the ID operands into EX-stage registers.
- Detects load-use hazards and inserts bubbles, stalling PC/IF-ID for a parameterised number of cycles.
- Applies branch/jump flushes and keeps saturating stall and flush event counters.

Parameters:
- LOAD_STALL_CYCLES, 1: Stall cycles inserted per load-use hazard; legal range 1..7.
- CNT_W, 32: Width of the performance counters.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high; clears all state
- Flush  in  1  branch/jump taken in EX; squash the instruction entering EX
- ID_RegDst, ID_ALUSource, ID_MemToReg, ID_RegWrite, ID_MemRead, ID_MemWrite  in  1 each  decoded control bits
- ID_BranchJump  in  2  decoded branch/jump class
- ID_ALUOp  in  5  decoded ALU operation
- ID_PCPlus4, ID_ReadData1, ID_ReadData2, ID_SignExtImm  in  32 each  ID operands
- ID_Rs, ID_Rt, ID_Rd  in  5 each  register specifiers
- EX_*  out  same widths  registered copies of every ID_* input above
- EX_WriteReg  out  5  registered destination: ID_Rd if ID_RegDst=1, else ID_Rt
- Stall  out  1  freeze PC and the IF/ID register this cycle
- StallCount, FlushCount  out  CNT_W  saturating event counters

Behaviour:
- Reset (async, any time, including mid-stall): all EX_* = 0, EX_WriteReg = 0, FSM = RUN, stall counter = 0, Stall = 0, StallCount = FlushCount = 0.
- Normal latency: 1 cycle. ID_* sampled at the rising edge appears on EX_* after that edge.
- Hazard, combinational: EX_MemRead & EX_RegWrite & (EX_WriteReg != 0) & ((EX_WriteReg == ID_Rs) | ((EX_WriteReg == ID_Rt) & (~ID_ALUSource | ID_MemWrite))).
- Bubble: at the edge, EX control bits (RegDst, ALUSource, MemToReg, RegWrite, MemRead, MemWrite, BranchJump, ALUOp) load 0. EX data, specifier and EX_WriteReg registers hold their previous value.
- FSM states:
  - RUN: if Flush, load a bubble; Stall = 0. Else if hazard, Stall = 1 and load a bubble; go to STALL with cnt = LOAD_STALL_CYCLES-1 when LOAD_STALL_CYCLES > 1, otherwise stay in RUN. Else load ID_*.
  - STALL: Stall = 1 and load a bubble. If cnt == 1, go to RUN; else cnt <= cnt-1. Hazard is not re-evaluated in STALL; the bubble clears EX_MemRead, so RUN does not re-trigger.
- Stall is asserted for exactly LOAD_STALL_CYCLES consecutive cycles per hazard. The held ID instruction latches on the first RUN cycle after the stall.
- Flush has priority over everything. In either state: load a bubble, go to RUN, cnt = 0, Stall = 0 that cycle. A flush arriving mid-stall aborts the stall.
- Counters:
  - StallCount += 1 on every cycle Stall = 1.
  - FlushCount += 1 on every cycle Flush = 1.
  - Both saturate at all-ones and do not wrap.
- Stall is combinational from the FSM state and the hazard term; no other output is combinational.
- Register $0 never causes a hazard.

Decomposition:
- Shared package holds:
  - the control-bundle struct (RegDst, ALUSource, MemToReg, RegWrite, MemRead, MemWrite, BranchJump[1:0], ALUOp[4:0]);
  - a BUBBLE constant (all zero);
  - the FSM state enum {RUN, STALL};
  - ALUOp width = 5.
- One sub-module, hazard_detect, holds the purely combinational hazard term. The FSM, pipeline registers and counters stay in id_ex_stage.

Test Plan:
- Reset mid-operation: assert Reset while in STALL with LOAD_STALL_CYCLES=3 -> all EX_* = 0, Stall = 0 immediately, StallCount = 0.
- Pass-through: addi control (RegDst=1, ALUSource=1, RegWrite=1, ALUOp=2), ReadData1=0x10, Rd=8 -> one cycle later EX_ALUOp=2, EX_ReadData1=0x10, EX_WriteReg=8, Stall=0.
- Load-use: lw with Rt=9 (RegDst=0, MemRead=1) then add with Rs=9 -> Stall=1 for 1 cycle, one bubble (EX_RegWrite=0), add latched next cycle, StallCount=1.
- Parameterised stall and false hazards: LOAD_STALL_CYCLES=3, lw to $t1 then sw using Rt=$t1 -> Stall high for exactly 3 cycles, StallCount=3. Same sequence with lw to $0, or a consumer addi whose Rt=$t1 with ALUSource=1 -> no stall.
- Flush mid-stall: LOAD_STALL_CYCLES=3, Flush=1 on the second stall cycle -> EX control = 0, Stall=0 that cycle, FSM RUN, FlushCount=1, StallCount=1.
- Saturation: CNT_W=4, hold Flush for 20 cycles -> FlushCount sticks at 15.
